// File: rtl/alu_pkg.sv
// Op encodings, flag bit positions and operand-preparation helpers shared by
// the adder pipeline and the ALU result mux.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } alu_op_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_W     = 3;

  // SUB is a + ~b + 1; ADC/SBB take the external carry, ADD forces zero.
  function automatic logic carry_in(input alu_op_e op, input logic cin);
    case (op)
      OP_ADD:  carry_in = 1'b0;
      OP_SUB:  carry_in = 1'b1;
      default: carry_in = cin;
    endcase
  endfunction

  function automatic logic invert_b(input alu_op_e op);
    invert_b = (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_group.sv
// One BLOCK-bit carry-lookahead group: every internal carry is a flat
// sum-of-products of g/p/cin, no ripple inside the group.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_g,
  input  logic [BLOCK-1:0] i_p,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout
);

  logic [BLOCK:0] w_c;

  always_comb begin
    logic term;
    w_c = '0;
    for (int i = 0; i <= BLOCK; i++) begin
      term = i_cin;
      for (int j = 0; j < i; j++) term = term & i_p[j];
      w_c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = i_g[j];
        for (int m = j + 1; m < i; m++) term = term & i_p[m];
        w_c[i] = w_c[i] | term;
      end
    end
  end

  assign o_sum  = i_p ^ w_c[BLOCK-1:0];
  assign o_cout = w_c[BLOCK];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor: stage k resolves operand segment k and
// hands its carry-out, partial sum and untouched operand bits to stage k+1.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;

  if (WIDTH % (STAGES * BLOCK) != 0) begin : g_chk_div
    $error("cla_addsub_pipe: WIDTH must be a multiple of STAGES*BLOCK");
  end
  if (STAGES < 1 || STAGES > WIDTH / BLOCK) begin : g_chk_stages
    $error("cla_addsub_pipe: STAGES out of range 1..WIDTH/BLOCK");
  end

  // Per-stage inputs: index 0 is the port side, index k>0 is stage k-1's register.
  logic [WIDTH-1:0]  w_a   [STAGES];
  logic [WIDTH-1:0]  w_bp  [STAGES];
  logic [WIDTH-1:0]  w_sum [STAGES];
  logic [TAG_W-1:0]  w_tag [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_zero;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] r_valid;

  logic [WIDTH-1:0]  r_out_sum;
  logic              r_out_carry;
  logic              r_out_ovf;
  logic              r_out_zero;
  logic [TAG_W-1:0]  r_out_tag;

  assign w_a[0]    = in_a;
  assign w_bp[0]   = invert_b(alu_op_e'(in_op)) ? ~in_b : in_b;
  assign w_cin[0]  = carry_in(alu_op_e'(in_op), in_cin);
  assign w_sum[0]  = '0;
  assign w_zero[0] = 1'b1;
  assign w_tag[0]  = in_tag;

  // A stage may load when it is empty or its successor is loading.
  always_comb begin
    logic ld;
    w_load = '0;
    w_vin  = '0;
    ld = ~r_valid[STAGES-1] | out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k < STAGES - 1) ld = ~r_valid[k] | ld;
      w_load[k] = ld;
    end
    w_vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) w_vin[k] = r_valid[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (w_load[k]) r_valid[k] <= w_vin[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   w_seg_a;
    logic [SEG-1:0]   w_seg_bp;
    logic [SEG-1:0]   w_seg_g;
    logic [SEG-1:0]   w_seg_p;
    logic [SEG-1:0]   w_seg_sum;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_seg_cout;
    logic             w_zero_nxt;
    logic             w_en;

    assign w_seg_a  = w_a[k][k*SEG +: SEG];
    assign w_seg_bp = w_bp[k][k*SEG +: SEG];
    assign w_seg_g  = w_seg_a & w_seg_bp;
    assign w_seg_p  = w_seg_a ^ w_seg_bp;
    assign w_en     = w_load[k] & w_vin[k];

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      logic w_gcin;
      logic w_gcout;
      if (j == 0) begin : g_first
        assign w_gcin = w_cin[k];
      end else begin : g_next
        assign w_gcin = g_grp[j-1].w_gcout;
      end
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .i_g    (w_seg_g[j*BLOCK +: BLOCK]),
        .i_p    (w_seg_p[j*BLOCK +: BLOCK]),
        .i_cin  (w_gcin),
        .o_sum  (w_seg_sum[j*BLOCK +: BLOCK]),
        .o_cout (w_gcout)
      );
    end

    assign w_seg_cout = g_grp[NGRP-1].w_gcout;
    assign w_zero_nxt = w_zero[k] & ~(|w_seg_sum);

    always_comb begin
      w_sum_nxt = w_sum[k];
      w_sum_nxt[k*SEG +: SEG] = w_seg_sum;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_bp;
      logic [WIDTH-1:0] r_sum;
      logic             r_c;
      logic             r_zero;
      logic [TAG_W-1:0] r_tag;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a    <= '0;
          r_bp   <= '0;
          r_sum  <= '0;
          r_c    <= 1'b0;
          r_zero <= 1'b0;
          r_tag  <= '0;
        end else if (w_en) begin
          r_a    <= w_a[k];
          r_bp   <= w_bp[k];
          r_sum  <= w_sum_nxt;
          r_c    <= w_seg_cout;
          r_zero <= w_zero_nxt;
          r_tag  <= w_tag[k];
        end
      end

      assign w_a[k+1]    = r_a;
      assign w_bp[k+1]   = r_bp;
      assign w_sum[k+1]  = r_sum;
      assign w_cin[k+1]  = r_c;
      assign w_zero[k+1] = r_zero;
      assign w_tag[k+1]  = r_tag;
    end else begin : g_last
      // Carry into the MSB is recoverable from its sum and propagate bits.
      logic w_c_msb;
      assign w_c_msb = w_seg_p[SEG-1] ^ w_seg_sum[SEG-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_sum   <= '0;
          r_out_carry <= 1'b0;
          r_out_ovf   <= 1'b0;
          r_out_zero  <= 1'b0;
          r_out_tag   <= '0;
        end else if (w_en) begin
          r_out_sum   <= w_sum_nxt;
          r_out_carry <= w_seg_cout;
          r_out_ovf   <= w_c_msb ^ w_seg_cout;
          r_out_zero  <= w_zero_nxt;
          r_out_tag   <= w_tag[k];
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_sum   = r_out_sum;
  assign out_carry = r_out_carry;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;
  assign out_tag   = r_out_tag;

endmodule
